// File: rtl/comparator_pkg.sv
// comparator_pkg: shared state encoding, result constants and expected-result helper
package comparator_pkg;
   typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
   localparam logic [2:0] RES_EQ = 3'b100;
   localparam logic [2:0] RES_GT = 3'b010;
   localparam logic [2:0] RES_LT = 3'b001;
   function automatic logic [2:0] expected_result(input logic [7:0] a, input logic [7:0] b);
      return a == b ? RES_EQ : a > b ? RES_GT : RES_LT;
   endfunction
endpackage

// File: rtl/comparator_golden.sv
// comparator_golden: combinational reference producing the expected {eq,gt,lt}
module comparator_golden
   import comparator_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [2:0]       res
);
   // operands are zero-extended so the helper sees unsigned values
   always_comb res = expected_result(8'(a), 8'(b));
endmodule

// File: rtl/comparator_bist_driver.sv
// comparator_bist_driver: walks all operand pairs of a comparator and checks its flags
module comparator_bist_driver
   import comparator_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int LAT   = 0,
   parameter int ERRW  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   input  logic             A_eq_B,
   input  logic             A_gt_B,
   input  logic             A_lt_B,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERRW-1:0]  err_count,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b
);
   localparam int VW = 2 * WIDTH;
   localparam int SW = $clog2(LAT + 2);
   state_t         state;
   logic [VW-1:0]  vec;
   logic [SW-1:0]  settle;
   logic           fail_seen;
   logic [2:0]     exp_res;
   logic           mismatch;
   logic [ERRW-1:0] err_next;
   assign {A, B} = vec;
   comparator_golden #(.WIDTH(WIDTH)) u_golden (.a(A), .b(B), .res(exp_res));
   // mismatch of the current vector and the saturating error count it would produce
   always_comb begin
      mismatch = {A_eq_B, A_gt_B, A_lt_B} != exp_res;
      err_next = mismatch && !(&err_count) ? err_count + 1'b1 : err_count;
   end
   // run sequencer: start from IDLE/DONE, hold each vector LAT+1 cycles, check on the last
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         vec       <= '0;
         settle    <= '0;
         fail_seen <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_a    <= '0;
         fail_b    <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= DRIVE;
                  vec       <= '0;
                  settle    <= '0;
                  fail_seen <= 1'b0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  err_count <= '0;
                  fail_a    <= '0;
                  fail_b    <= '0;
               end
            end
            DRIVE: begin
               if (settle == SW'(LAT)) begin
                  err_count <= err_next;
                  if (mismatch && !fail_seen) begin
                     fail_seen <= 1'b1;
                     fail_a    <= A;
                     fail_b    <= B;
                  end
                  if (&vec) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= err_next == '0;
                  end else begin
                     vec    <= vec + 1'b1;
                     settle <= '0;
                  end
               end else begin
                  settle <= settle + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_comparator_bist_driver.sv
// tb_comparator_bist_driver: scoreboard bench with a faultable pipelined comparator model
module tb_comparator_bist_driver;
   localparam int WIDTH = 2;
   localparam int LAT   = 2;
   localparam int ERRW  = 3;
   localparam int NV    = 1 << (2 * WIDTH);
   localparam int RUNLEN = NV * (LAT + 1);
   localparam int ERRMAX = (1 << ERRW) - 1;

   typedef struct {
      int err;
      int fa;
      int fb;
      bit pass;
      int start_cyc;
   } exp_t;

   logic clk = 0, rst = 1, start = 0;
   logic [WIDTH-1:0] A, B, fail_a, fail_b;
   logic A_eq_B, A_gt_B, A_lt_B, busy, done, pass;
   logic [ERRW-1:0] err_count;
   int checks = 0, errors = 0, cyc = 0;
   int mode = 0, key = 0, bad_idx = 0;
   logic [2:0] bad_val = 3'b000;
   exp_t q[$];
   logic [2:0] comb_f, p1, p2;
   logic done_q = 0;

   comparator_bist_driver #(.WIDTH(WIDTH), .LAT(LAT), .ERRW(ERRW)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .A_eq_B(A_eq_B), .A_gt_B(A_gt_B), .A_lt_B(A_lt_B),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_a(fail_a), .fail_b(fail_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // comparator under test: flags in {eq,gt,lt} order with optional faults
   function automatic logic [2:0] dut_flags(int m, int a, int b, int k, int bi, logic [2:0] bv);
      logic [2:0] r;
      r = {a == b, a > b, a < b};
      if (m == 1) r[1] = 1'b0;
      if (m == 2) r = 3'b000;
      if (m == 3 && (a ^ b) == k) r = 3'b111;
      if (m == 4 && a * NV / (1 << WIDTH) + b == bi) r = bv;
      return r;
   endfunction

   always_comb comb_f = dut_flags(mode, int'(A), int'(B), key, bad_idx, bad_val);
   always @(posedge clk) begin
      p1 <= comb_f;
      p2 <= p1;
   end
   assign {A_eq_B, A_gt_B, A_lt_B} = p2;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // reference: whole-run outcome from the comparison rules
   function automatic exp_t model(int m, int k, int bi, logic [2:0] bv, int sc);
      exp_t e;
      int cnt = 0;
      e.fa = 0;
      e.fb = 0;
      for (int a = 0; a < (1 << WIDTH); a++)
         for (int b = 0; b < (1 << WIDTH); b++) begin
            int want;
            want = a == b ? 4 : a > b ? 2 : 1;
            if (int'(dut_flags(m, a, b, k, bi, bv)) != want) begin
               if (cnt == 0) begin
                  e.fa = a;
                  e.fb = b;
               end
               cnt++;
            end
         end
      e.err = cnt > ERRMAX ? ERRMAX : cnt;
      e.pass = cnt == 0;
      e.start_cyc = sc;
      return e;
   endfunction

   // monitor: vector order while busy, and full result when done rises
   always @(negedge clk) begin
      if (!rst) begin
         if (busy && q.size() > 0)
            chk("vector", int'({A, B}), (cyc - q[0].start_cyc) / (LAT + 1));
         if (done && !done_q) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no run");
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("err_count", int'(err_count), e.err);
               chk("fail_a", int'(fail_a), e.fa);
               chk("fail_b", int'(fail_b), e.fb);
               chk("pass", int'(pass), int'(e.pass));
               chk("run_len", cyc - e.start_cyc, RUNLEN);
            end
         end
      end
      done_q <= done;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic run(input int m, input bit mid_start);
      int n = 0;
      mode = m;
      key = $urandom_range(0, (1 << WIDTH) - 1);
      bad_idx = $urandom_range(0, NV - 1);
      bad_val = 3'($urandom_range(0, 7));
      step();
      start = 1;
      q.push_back(model(m, key, bad_idx, bad_val, cyc + 1));
      step();
      start = 0;
      if (mid_start) begin
         repeat (10) step();
         start = 1;
         step();
         start = 0;
      end
      while (!done && n < 4 * RUNLEN) begin
         step();
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL timeout: got done=0 expected done=1");
         q.delete();
      end
      step();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_pass"}, int'(pass), 0);
      chk({tag, "_err"}, int'(err_count), 0);
      chk({tag, "_fail_ab"}, int'({fail_a, fail_b}), 0);
      chk({tag, "_ab"}, int'({A, B}), 0);
   endtask

   initial begin
      int n;
      repeat (3) step();
      check_zero("reset");
      rst = 0;
      run(0, 0);
      run(1, 0);
      run(2, 0);
      run(0, 1);
      for (int i = 0; i < 6; i++) run($urandom_range(0, 4), $urandom_range(0, 1) == 1);
      mode = 2;
      step();
      start = 1;
      q.push_back(model(2, 0, 0, 3'b000, cyc + 1));
      step();
      start = 0;
      n = 0;
      while (!({A, B} == 4'(1) && busy) && n < 20) begin
         step();
         n++;
      end
      chk("reach_0_1", int'({A, B}), 1);
      rst = 1;
      q.delete();
      step();
      rst = 0;
      check_zero("midrst");
      run(0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
